// File: rtl/axi_burst_stimulator.sv
// Command-driven AXI3 burst master: GPIO-style cmd/status words drive INCR read/write
// bursts on one HP port; B and R responses are queued in a small FIFO for readback.
module axi_burst_stimulator #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int MAX_BURST  = 16,
  parameter int RX_DEPTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [31:0]             cmd,
  output logic [31:0]             status,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             awaddr,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic [3:0]              awqos,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic [ID_WIDTH-1:0]     wid,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [ID_WIDTH-1:0]     bid,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [31:0]             araddr,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic [3:0]              arqos,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic                    rlast
);
  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  localparam int QW   = $clog2(MAX_BURST);
  localparam int CW   = $clog2(MAX_BURST + 1);
  localparam int PW   = $clog2(RX_DEPTH);
  localparam int MW   = 4 + ID_WIDTH;
  localparam int EW   = MW + DATA_WIDTH;

  localparam logic [7:0] OP_ADDR = 8'h00, OP_ID = 8'h01, OP_LEN = 8'h02, OP_CACHE = 8'h03;
  localparam logic [7:0] OP_SHIFT = 8'h04, OP_PUSH = 8'h05, OP_WSTART = 8'h06, OP_RSTART = 8'h07;
  localparam logic [7:0] OP_POP = 8'h08, OP_CLEAR = 8'h09;
  localparam logic [7:0] OP_GET_STATUS = 8'h10, OP_GET_LO = 8'h11, OP_GET_HI = 8'h12, OP_GET_META = 8'h13;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WADDR = 2'd1, S_WDATA = 2'd2, S_RADDR = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              beat_q, beat_d;
  logic [31:0]             addr_q, addr_d, b_addr_q, b_addr_d;
  logic [ID_WIDTH-1:0]     id_q, id_d, b_id_q, b_id_d;
  logic [3:0]              len_q, len_d, b_len_q, b_len_d;
  logic [3:0]              cache_q, cache_d, b_cache_q, b_cache_d;
  logic [2:0]              prot_q, prot_d, b_prot_q, b_prot_d;
  logic [DATA_WIDTH-1:0]   stage_q, stage_d;
  logic [DATA_WIDTH-1:0]   wq_q [MAX_BURST];
  logic [DATA_WIDTH-1:0]   wq_d [MAX_BURST];
  logic [CW-1:0]           wcount_q, wcount_d;
  logic [1:0]              sel_q, sel_d;
  logic                    err_cmd_q, err_cmd_d, err_resp_q, err_resp_d;
  logic [EW-1:0]           mem_q [RX_DEPTH];
  logic [EW-1:0]           mem_d [RX_DEPTH];
  logic [PW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]             cnt_q, cnt_d;

  logic [7:0]  op;
  logic [23:0] field;
  logic        idle, snap, wq_full, wq_enough;
  logic        full, empty, push_b, push_r, push, do_pop, do_clear;
  logic [EW-1:0]          push_entry, head;
  logic [63:0]            head64;
  logic [MW-1:0]          head_meta;

  assign op        = cmd[31:24];
  assign field     = cmd[23:0];
  assign idle      = (state_q == S_IDLE);
  assign wq_full   = (wcount_q == CW'(MAX_BURST));
  assign wq_enough = (32'(wcount_q) >= 32'(len_q) + 32'd1);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    id_d       = id_q;
    len_d      = len_q;
    cache_d    = cache_q;
    prot_d     = prot_q;
    stage_d    = stage_q;
    wq_d       = wq_q;
    wcount_d   = wcount_q;
    sel_d      = sel_q;
    err_cmd_d  = err_cmd_q;
    b_addr_d   = b_addr_q;
    b_id_d     = b_id_q;
    b_len_d    = b_len_q;
    b_cache_d  = b_cache_q;
    b_prot_d   = b_prot_q;
    snap       = 1'b0;

    case (state_q)
      S_WADDR: if (awready) begin
        state_d = S_WDATA;
        beat_d  = 4'd0;
      end
      S_WDATA: if (wready) begin
        if (beat_q == b_len_q) begin
          state_d  = S_IDLE;
          wcount_d = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_RADDR: if (arready) state_d = S_IDLE;
      default: ;
    endcase

    // Command decode runs after the FSM so CLEAR/PUSH win over the end-of-burst wcount reset.
    if (cmd_valid) begin
      case (op)
        OP_ADDR:  addr_d = {field, 8'h00};
        OP_ID:    id_d = field[ID_WIDTH-1:0];
        OP_LEN:   len_d = field[3:0];
        OP_CACHE: begin
          cache_d = field[3:0];
          prot_d  = field[6:4];
        end
        OP_SHIFT: stage_d = DATA_WIDTH'({stage_q, field[15:0]});
        OP_PUSH: if (!wq_full) begin
          wq_d[wcount_q[QW-1:0]] = stage_q;
          wcount_d = wcount_q + CW'(1);
        end
        OP_WSTART: if (idle && wq_enough) begin
          state_d = S_WADDR;
          snap    = 1'b1;
        end else begin
          err_cmd_d = 1'b1;
        end
        OP_RSTART: if (idle) begin
          state_d = S_RADDR;
          snap    = 1'b1;
        end else begin
          err_cmd_d = 1'b1;
        end
        OP_CLEAR: begin
          wcount_d  = '0;
          err_cmd_d = 1'b0;
        end
        OP_GET_STATUS, OP_GET_LO, OP_GET_HI, OP_GET_META: sel_d = op[1:0];
        default: ;
      endcase
    end

    if (snap) begin
      b_addr_d  = addr_q;
      b_id_d    = id_q;
      b_len_d   = len_q;
      b_cache_d = cache_q;
      b_prot_d  = prot_q;
    end
  end

  // Response FIFO: B has priority over R, at most one push per cycle.
  assign full     = (cnt_q == (PW+1)'(RX_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_b   = bvalid && !full;
  assign push_r   = rvalid && !full && !bvalid;
  assign push     = push_b || push_r;
  assign do_pop   = cmd_valid && (op == OP_POP) && !empty;
  assign do_clear = cmd_valid && (op == OP_CLEAR);
  assign push_entry = push_b ? {1'b1, 1'b1, bresp, bid, DATA_WIDTH'(0)}
                             : {1'b0, rlast, rresp, rid, rdata};

  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    err_resp_d = err_resp_q;
    if (do_clear) begin
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      err_resp_d = 1'b0;
    end else if (do_pop) begin
      rd_d  = rd_q + PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end
    if (push) begin
      mem_d[wr_d] = push_entry;
      wr_d        = wr_d + PW'(1);
      cnt_d       = cnt_d + (PW+1)'(1);
      if (push_entry[EW-3 -: 2] != 2'b00) err_resp_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      cache_q    <= '0;
      prot_q     <= '0;
      stage_q    <= '0;
      wcount_q   <= '0;
      sel_q      <= '0;
      err_cmd_q  <= 1'b0;
      err_resp_q <= 1'b0;
      b_addr_q   <= '0;
      b_id_q     <= '0;
      b_len_q    <= '0;
      b_cache_q  <= '0;
      b_prot_q   <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      cache_q    <= cache_d;
      prot_q     <= prot_d;
      stage_q    <= stage_d;
      wcount_q   <= wcount_d;
      sel_q      <= sel_d;
      err_cmd_q  <= err_cmd_d;
      err_resp_q <= err_resp_d;
      b_addr_q   <= b_addr_d;
      b_id_q     <= b_id_d;
      b_len_q    <= b_len_d;
      b_cache_q  <= b_cache_d;
      b_prot_q   <= b_prot_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by wcount and cnt.
  always_ff @(posedge clock) begin
    wq_q  <= wq_d;
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_q];
  assign head64    = 64'(head[DATA_WIDTH-1:0]);
  assign head_meta = head[EW-1:DATA_WIDTH];

  always_comb begin
    status = '0;
    case (sel_q)
      2'd0: status = {!idle, 2'(state_q), err_cmd_q, err_resp_q, 8'(cnt_q), 5'(wcount_q), 14'b0};
      2'd1: status = empty ? 32'd0 : head64[31:0];
      2'd2: status = empty ? 32'd0 : head64[63:32];
      default: status = empty ? 32'd0 : 32'(head_meta);
    endcase
  end

  assign awvalid = (state_q == S_WADDR);
  assign awaddr  = b_addr_q;
  assign awid    = b_id_q;
  assign awlen   = b_len_q;
  assign awsize  = 3'(SIZE);
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = b_cache_q;
  assign awprot  = b_prot_q;
  assign awqos   = 4'd0;

  assign wvalid  = (state_q == S_WDATA);
  assign wdata   = wq_q[beat_q[QW-1:0]];
  assign wstrb   = '1;
  assign wlast   = wvalid && (beat_q == b_len_q);
  assign wid     = b_id_q;

  assign bready  = !full;
  assign rready  = !full && !bvalid;

  assign arvalid = (state_q == S_RADDR);
  assign araddr  = b_addr_q;
  assign arid    = b_id_q;
  assign arlen   = b_len_q;
  assign arsize  = 3'(SIZE);
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = b_cache_q;
  assign arprot  = b_prot_q;
  assign arqos   = 4'd0;
endmodule
